u_divider_8bit_seq: RTL and testbench

- Sequential unsigned restoring divider; the inverse operation to the team's 8-bit unsigned multiplier.
- Divides a 2*DW-bit dividend by a DW-bit divisor, producing one quotient bit per clock.
- Outputs are a 2*DW-bit quotient and a DW-bit remainder, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit; the sequencer drives start and waits for done.

---
 rtl/u_divider_8bit_seq.sv | 111 +++++++++++
 tb/tb_u_divider_8bit_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/u_divider_8bit_seq.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Define U_DIV_DBZ_FLAG_EN to add the dbz port and a 2-clock divide-by-zero shortcut.
module u_divider_8bit_seq #(
  parameter int DW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic [2*DW-1:0] quot,
  output logic [DW-1:0]   rem,
  output logic            busy,
  output logic            eod
`ifdef U_DIV_DBZ_FLAG_EN
  ,
  output logic            dbz
`endif
);

  localparam int CW = $clog2(2*DW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] shq;
  logic [DW-1:0]   dvs;
  logic [DW:0]     pr;

  logic [DW:0] pr_sh;
  logic [DW:0] diff;
  logic [DW:0] pr_nx;
  logic        qbit;
  logic        last;

  // shq feeds dividend bits out of its top while quotient bits enter at the bottom
  always_comb begin
    pr_sh = {pr[DW-1:0], shq[2*DW-1]};
    diff  = pr_sh - {1'b0, dvs};
    qbit  = (pr_sh >= {1'b0, dvs});
    pr_nx = qbit ? diff : pr_sh;
    last  = (cnt == CW'(2*DW-1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shq   <= '0;
      dvs   <= '0;
      pr    <= '0;
      quot  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      eod   <= 1'b0;
`ifdef U_DIV_DBZ_FLAG_EN
      dbz   <= 1'b0;
`endif
    end else begin
      eod <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shq   <= dividend;
            dvs   <= divisor;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
`ifdef U_DIV_DBZ_FLAG_EN
            if (divisor != '0)
              dbz <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
`ifdef U_DIV_DBZ_FLAG_EN
          if (dvs == '0) begin
            quot  <= '1;
            rem   <= shq[DW-1:0];
            dbz   <= 1'b1;
            busy  <= 1'b0;
            eod   <= 1'b1;
            state <= DONE;
          end else
`endif
          if (last) begin
            quot  <= {shq[2*DW-2:0], qbit};
            rem   <= pr_nx[DW-1:0];
            busy  <= 1'b0;
            eod   <= 1'b1;
            state <= DONE;
          end else begin
            shq <= {shq[2*DW-2:0], qbit};
            pr  <= pr_nx;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u_divider_8bit_seq.sv
// Self-checking bench for u_divider_8bit_seq: table vectors, corner sequences, random vs model.
// Honours U_DIV_DBZ_FLAG_EN for the dbz port and short divide-by-zero latency.
module tb_u_divider_8bit_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        busy;
  logic        eod;
`ifdef U_DIV_DBZ_FLAG_EN
  logic        dbz;
`endif

  int total = 0;
  int bad   = 0;

  u_divider_8bit_seq #(.DW(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .eod      (eod)
`ifdef U_DIV_DBZ_FLAG_EN
    ,
    .dbz      (dbz)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef U_DIV_DBZ_FLAG_EN
    return (b == 8'd0) ? 2 : 17;
`else
    return 17;
`endif
  endfunction

  // Drives start for the current cycle; returns #1 after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Called at a negedge; counts clocks from the accepting edge until eod.
  task automatic wait_eod(input int l0, output int lat);
    lat = l0;
    while (!eod && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!eod) begin
      total++;
      bad++;
      $display("FAIL eod_timeout: got no eod after %0d clocks", lat);
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] q, input logic [7:0] r,
                         input string name);
    int lat;
    @(negedge clock);
    launch(a, b);
    @(negedge clock);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_eod(1, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    chk({name, "_quot"}, 32'(quot), 32'(q));
    chk({name, "_rem"}, 32'(rem), 32'(r));
    chk({name, "_busy_at_eod"}, 32'(busy), 32'd0);
`ifdef U_DIV_DBZ_FLAG_EN
    chk({name, "_dbz"}, 32'(dbz), 32'(b == 8'd0));
`endif
    @(negedge clock);
    chk({name, "_eod_pulse"}, 32'(eod), 32'd0);
  endtask

  initial begin
    int lat;
    int neod;
    logic [15:0] a;
    logic [7:0]  b;

    tbl[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6};
    tbl[1] = '{a: 16'hFFFF,  b: 8'hFF,  q: 16'd257,   r: 8'd0};
    tbl[2] = '{a: 16'd5,     b: 8'd9,   q: 16'd0,     r: 8'd5};
    tbl[3] = '{a: 16'hABCD,  b: 8'd0,   q: 16'hFFFF,  r: 8'hCD};
    tbl[4] = '{a: 16'd100,   b: 8'd10,  q: 16'd10,    r: 8'd0};
    tbl[5] = '{a: 16'd9,     b: 8'd3,   q: 16'd3,     r: 8'd0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eod", 32'(eod), 32'd0);
`ifdef U_DIV_DBZ_FLAG_EN
    chk("rst_dbz", 32'(dbz), 32'd0);
`endif

    for (int i = 0; i < 6; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

    // start pulsed mid-iteration must be ignored
    @(negedge clock);
    launch(16'd1000, 8'd7);
    repeat (4) @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 8'd3;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    wait_eod(6, lat);
    chk("ign_lat", 32'(lat), 32'd17);
    chk("ign_quot", 32'(quot), 32'd142);
    chk("ign_rem", 32'(rem), 32'd6);

    // start accepted during DONE; outputs hold until the next completion
    launch(16'd9, 8'd3);
    @(negedge clock);
    chk("done_start_hold_quot", 32'(quot), 32'd142);
    chk("done_start_busy", 32'(busy), 32'd1);
    wait_eod(1, lat);
    chk("done_start_lat", 32'(lat), 32'd17);
    chk("done_start_quot", 32'(quot), 32'd3);
    chk("done_start_rem", 32'(rem), 32'd0);

    // reset in the middle of a division
    @(negedge clock);
    launch(16'd1000, 8'd7);
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_eod", 32'(eod), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
    neod = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (eod) neod++;
    end
    chk("midrst_no_eod", 32'(neod), 32'd0);
    run_div(16'd100, 8'd10, 16'd10, 8'd0, "after_rst");

    // random operands against plain arithmetic
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0)
        run_div(a, b, 16'hFFFF, a[7:0], $sformatf("rnd%0d", i));
      else
        run_div(a, b, a / 16'(b), 8'(a % 16'(b)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
